shift_sub_divider: RTL
======================

// Module: shift_sub_divider
// PURPOSE
//  Iterative restoring divider; inverse of the add-shift multiplier datapath.
//  Divisor loaded from switches, then Run loads dividend and performs one
//  shift/trial-subtract per clock. Quotient and remainder held for display.
//  Inputs arrive already synchronized to Clk; synchronizers and hex driver live in the toplevel.
// PARAMETERS
//  WIDTH  8  operand/quotient/remainder width in bits (>=2)
// PORTS
//  Clk           in   1      system clock, all state on rising edge
//  Reset_n       in   1      asynchronous active-low reset
//  Load_Divisor  in   1      level; in IDLE loads SW into divisor register D
//  Run           in   1      level; in IDLE loads SW as dividend and starts
//  SW            in   WIDTH  operand input (divisor or dividend)
//  Qval          out  WIDTH  quotient register
//  Rval          out  WIDTH  remainder register
//  Dval          out  WIDTH  divisor register (for display)
//  Busy          out  1      high in CALC (and FIX when compiled in)
//  Done          out  1      high in DONE
//  Div0          out  1      sticky-until-next-start divide-by-zero flag
// BEHAVIOUR
//  Reset (Reset_n=0, async): state=IDLE; Qval=Rval=Dval=0; cnt=0; Busy=Done=Div0=0.
//  States: IDLE -> CALC -> (FIX) -> DONE -> IDLE. All outputs registered.
//  IDLE: Load_Divisor=1 -> D<=SW, stay IDLE. Load_Divisor has priority over
//   Run in the same cycle (Run ignored that cycle, honoured next if still high).
//   Run=1 & Load_Divisor=0 -> Q<=SW, R<=0, cnt<=0, Div0<=0;
//   if D==0: Q<=all-ones, R<=SW, Div0<=1, go DONE (no CALC cycles).
//   else go CALC.
//  CALC (exactly WIDTH cycles): t = {R, Q[WIDTH-1]} - {1'b0, D} in WIDTH+1 bits.
//   t[WIDTH]==0 (no borrow): R<=t[WIDTH-1:0], Q<={Q[WIDTH-2:0],1}.
//   else (restore): R<={R[WIDTH-2:0],Q[WIDTH-1]}, Q<={Q[WIDTH-2:0],0}.
//   cnt increments; on cnt==WIDTH-1 go DONE (or FIX).
//  Latency (unsigned): Run sampled in IDLE at edge k -> Done=1 after edge k+WIDTH+1.
//  DONE: Qval/Rval stable; stay while Run=1; Run=0 -> IDLE (one result per press).
//  Run/Load_Divisor/SW changes during CALC/FIX are ignored; D never changes mid-op.
//  Reset asserted mid-CALC: immediate return to reset values; no partial result kept.
//  Invariant on completion (D!=0): SW_dividend == Qval*D + Rval, Rval < D.
// CONFIGURATION
//  SIGNED_DIV_EN defined: operands two's complement.
//   Start: magnitudes of dividend and D used in CALC; signs latched.
//   Extra FIX state (1 cycle) after CALC: Q negated if signs differ; R negated
//   if dividend negative (truncate toward zero, remainder takes dividend sign).
//   Latency becomes WIDTH+2. Busy high in FIX.
//   Most-negative / -1 (e.g. -128/-1): Qval=0x80, Rval=0, Div0=0 (wraps).
//   D==0: Qval=all-ones, Rval=dividend, Div0=1, no FIX.
//  SIGNED_DIV_EN undefined: unsigned only, FIX state and sign logic absent.
// TESTING
//  1. Reset_n pulse; Load_Divisor with SW=0x07; Run with SW=0x64 -> after 9
//     edges Done=1, Qval=0x0E, Rval=0x02; Run low -> IDLE, Done=0.
//  2. D=0x01, dividend 0xFF -> Qval=0xFF, Rval=0x00; D=0x09, dividend 0x05 ->
//     Qval=0x00, Rval=0x05.
//  3. D=0x00, Run SW=0x2A -> next edge Done=1, Div0=1, Qval=0xFF, Rval=0x2A;
//     next valid run clears Div0.
//  4. Load_Divisor and Run high same cycle in IDLE -> D loaded, start delayed one
//     cycle; Load_Divisor toggled mid-CALC -> Dval unchanged, result correct.
//  5. Reset_n low at CALC cycle 4 -> outputs zero immediately, state IDLE.
//  6. SIGNED_DIV_EN: D=0x07, dividend 0x9C (-100) -> Qval=0xF2, Rval=0xFE after
//     10 edges; D=0xFF, dividend 0x80 -> Qval=0x80, Rval=0x00.

Source files
------------

// File: rtl/shift_sub_divider.sv
// Iterative restoring divider: one shift/trial-subtract per clock, result held for display.
// Optional two's-complement operands when compiled with SIGNED_DIV_EN.
module shift_sub_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Load_Divisor,
    input  logic             Run,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Qval,
    output logic [WIDTH-1:0] Rval,
    output logic [WIDTH-1:0] Dval,
    output logic             Busy,
    output logic             Done,
    output logic             Div0
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
`ifdef SIGNED_DIV_EN
        S_FIX  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [WIDTH-1:0] r_r, w_r_nxt;
    logic [WIDTH-1:0] r_d, w_d_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_div0, w_div0_nxt;
    logic [WIDTH-1:0] w_dmag;
    logic [WIDTH:0]   w_trial;

`ifdef SIGNED_DIV_EN
    logic             r_neg_q, w_neg_q_nxt;
    logic             r_neg_r, w_neg_r_nxt;

    // CALC always works on magnitudes; signs are reapplied in FIX.
    assign w_dmag = r_d[WIDTH-1] ? -r_d : r_d;
`else
    assign w_dmag = r_d;
`endif

    // Remainder stays below the divisor, so the shifted partial fits in WIDTH+1 bits.
    assign w_trial = {r_r, r_q[WIDTH-1]} - {1'b0, w_dmag};

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_r_nxt     = r_r;
        w_d_nxt     = r_d;
        w_cnt_nxt   = r_cnt;
        w_div0_nxt  = r_div0;
`ifdef SIGNED_DIV_EN
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
`endif
        case (r_state)
            S_IDLE: begin
                if (Load_Divisor) begin
                    w_d_nxt = SW;
                end else if (Run) begin
                    w_cnt_nxt  = '0;
                    if (r_d == '0) begin
                        w_q_nxt     = '1;
                        w_r_nxt     = SW;
                        w_div0_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_r_nxt     = '0;
                        w_div0_nxt  = 1'b0;
                        w_state_nxt = S_CALC;
`ifdef SIGNED_DIV_EN
                        w_q_nxt     = SW[WIDTH-1] ? -SW : SW;
                        w_neg_q_nxt = SW[WIDTH-1] ^ r_d[WIDTH-1];
                        w_neg_r_nxt = SW[WIDTH-1];
`else
                        w_q_nxt     = SW;
`endif
                    end
                end
            end
            S_CALC: begin
                if (!w_trial[WIDTH]) begin
                    w_r_nxt = w_trial[WIDTH-1:0];
                    w_q_nxt = {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    w_r_nxt = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
                    w_q_nxt = {r_q[WIDTH-2:0], 1'b0};
                end
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CNT_LAST) begin
`ifdef SIGNED_DIV_EN
                    w_state_nxt = S_FIX;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef SIGNED_DIV_EN
            S_FIX: begin
                if (r_neg_q) w_q_nxt = -r_q;
                if (r_neg_r) w_r_nxt = -r_r;
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                if (!Run) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status flags are registered decodes of the current state, so they trail it by one clock.
`ifdef SIGNED_DIV_EN
    assign w_busy_nxt = (r_state == S_CALC) || (r_state == S_FIX);
`else
    assign w_busy_nxt = (r_state == S_CALC);
`endif
    assign w_done_nxt = (r_state == S_DONE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_r     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_r     <= w_r_nxt;
            r_d     <= w_d_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_div0  <= w_div0_nxt;
`ifdef SIGNED_DIV_EN
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
`endif
        end
    end

    assign Qval = r_q;
    assign Rval = r_r;
    assign Dval = r_d;
    assign Busy = r_busy;
    assign Done = r_done;
    assign Div0 = r_div0;

endmodule
